dec_align: RTL

Parametrised instruction-alignment buffer sitting between fetch and decode. It accepts fetch words of FETCH_W bits, stores them as a circular queue of 16-bit halfwords, and emits one aligned 16- or 32-bit instruction per cycle. The emitted instruction carries its PC, a compressed flag and any fetch fault. It generalises the 16/32-bit selection in decode to wide fetch words and to 32-bit instructions straddling fetch-word boundaries, with valid/ready handshakes and redirect flushing.

---
 rtl/isa_pkg.sv | 19 +
 rtl/hw_ring.sv | 38 +++
 rtl/dec_align.sv | 139 +++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared fetch-side ISA definitions: fault cause codes, the stored halfword
// layout and the compressed-length rule used by the alignment buffer.
package isa_pkg;

    localparam logic [4:0] CAUSE_NONE            = 5'd0;
    localparam logic [4:0] CAUSE_INST_ACCESS     = 5'd1;
    localparam logic [4:0] CAUSE_INST_PAGE_FAULT = 5'd12;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  cause;
    } hw_t;

    // A halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/hw_ring.sv
// Halfword ring: variable-length write of up to NH consecutive entries and
// two read ports at rd_ptr and rd_ptr+1, both wrapping modulo DEPTH.
module hw_ring
    import isa_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NH    = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNW  = $clog2(NH) + 1
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_ptr,
    input  logic [CNW-1:0]      wr_cnt,
    input  hw_t  [NH-1:0]       wr_data,
    input  logic [AW-1:0]       rd_ptr,
    output hw_t                 rd0,
    output hw_t                 rd1
);

    hw_t mem [DEPTH];

    // NOTE: the storage array has no reset; count and the pointers decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NH; i++) begin
                if (i < int'(wr_cnt)) begin
                    mem[wr_ptr + AW'(i)] <= wr_data[i];
                end
            end
        end
    end

    assign rd0 = mem[rd_ptr];
    assign rd1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/dec_align.sv
// Instruction alignment buffer: queues fetch words as halfwords and emits one
// aligned 16/32-bit instruction per cycle with its PC and any fetch fault.
module dec_align
    import isa_pkg::*;
#(
    parameter int FETCH_W = 64,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [63:0]        flush_pc,
    input  logic               f_valid,
    output logic               f_ready,
    input  logic [FETCH_W-1:0] f_data,
    input  logic [4:0]         f_cause,
    input  logic [63:0]        f_tval,
    output logic               i_valid,
    input  logic               i_ready,
    output logic [63:0]        i_pc,
    output logic [31:0]        i_inst,
    output logic               i_compressed,
    output logic [4:0]         i_cause,
    output logic [63:0]        i_tval
);

    localparam int NH  = FETCH_W / 16;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SKW = $clog2(NH);
    localparam int CNW = SKW + 1;

    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic [63:0]    pc_q, tval_q;
    logic [SKW-1:0] skip_q;
    logic           skip_pend;

    hw_t            h0, h1;
    hw_t [NH-1:0]   wr_data;
    logic [SKW-1:0] skip_eff;
    logic [CNW-1:0] push_n;
    logic [1:0]     pop_n;
    logic           head_c, h0_fault, h1_fault, has_two;
    logic           do_push, do_pop;

    assign f_ready  = (CW'(DEPTH) - count) >= CW'(NH);
    assign do_push  = f_valid && f_ready && !flush;
    assign do_pop   = i_valid && i_ready && !flush;
    assign skip_eff = skip_pend ? skip_q : '0;
    assign push_n   = CNW'(NH) - CNW'(skip_eff);

    // Halfwords below the post-redirect entry point are shifted out of the word.
    always_comb begin
        for (int i = 0; i < NH; i++) begin
            wr_data[i] = '0;
            for (int j = 0; j < NH; j++) begin
                if (j == i + int'(skip_eff)) begin
                    wr_data[i] = '{data: f_data[16*j +: 16], cause: f_cause};
                end
            end
        end
    end

    hw_ring #(.DEPTH(DEPTH), .NH(NH)) u_ring (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_ptr  (wr_ptr),
        .wr_cnt  (push_n),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd0     (h0),
        .rd1     (h1)
    );

    // Head decode; a faulting head halfword is emitted even without its partner.
    always_comb begin
        head_c       = is_compressed(h0.data);
        h0_fault     = h0.cause != CAUSE_NONE;
        h1_fault     = h1.cause != CAUSE_NONE;
        has_two      = count >= CW'(2);
        i_valid      = (count != '0) && (head_c || h0_fault || has_two);
        pop_n        = (!head_c && has_two) ? 2'd2 : 2'd1;
        i_pc         = pc_q;
        i_inst       = '0;
        i_compressed = 1'b0;
        i_cause      = CAUSE_NONE;
        i_tval       = '0;
        if (i_valid) begin
            i_compressed = head_c;
            if (h0_fault) begin
                i_cause = h0.cause;
                i_tval  = tval_q;
            end else if (!head_c && h1_fault) begin
                i_cause = h1.cause;
                i_tval  = pc_q + 64'd2;
            end else if (head_c) begin
                i_inst = {16'h0000, h0.data};
            end else begin
                i_inst = {h1.data, h0.data};
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational logic above.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pc_q      <= '0;
            tval_q    <= '0;
            skip_q    <= '0;
            skip_pend <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pc_q      <= flush_pc & ~64'd1;
            skip_q    <= flush_pc[SKW:1];
            skip_pend <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr    <= wr_ptr + AW'(push_n);
                skip_pend <= 1'b0;
                if (f_cause != CAUSE_NONE) begin
                    tval_q <= f_tval;
                end
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(pop_n);
                pc_q   <= pc_q + {61'd0, pop_n, 1'b0};
            end
            count <= count + (do_push ? CW'(push_n) : CW'(0)) - (do_pop ? CW'(pop_n) : CW'(0));
        end
    end

endmodule
